// File: rtl/clock_management_core_pkg.sv
// Shared constants and helpers for the clock management slice.
//   F100_HZ / F10_HZ          : derived clock frequencies
//   BASE_HZ                   : clk_in must be a multiple of this
//   RST_HOLD_CYCLES_DEFAULT   : default derived-clock cycles rstb is held low
//   half_ratio()              : clk_in cycles per half period of a derived clock
//   cnt_width()               : bits needed to count 0..n-1 (never below 1)
package clock_management_core_pkg;

  localparam int unsigned F100_HZ                 = 100_000_000;
  localparam int unsigned F10_HZ                  = 10_000_000;
  localparam int unsigned BASE_HZ                 = 2 * F100_HZ;
  localparam int unsigned RST_HOLD_CYCLES_DEFAULT = 16;

  function automatic int unsigned half_ratio(input int unsigned clk_hz,
                                             input int unsigned out_hz);
    return clk_hz / (2 * out_hz);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_management_core_divider_rst.sv
// clock_divider_rst: counter divider plus its domain reset generator.
//   clk_in   : master clock
//   rst      : synchronous active-high reset
//   clk_out  : divided clock, toggles whenever the counter is 0
//   rstb_out : active-low domain reset, released on the falling edge of
//              clk_out after RST_HOLD_CYCLES rising edges
module clock_divider_rst
  import clock_management_core_pkg::*;
#(
  parameter int unsigned HALF            = 1,
  parameter int unsigned RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out,
  output logic rstb_out
);

  localparam int unsigned   CW       = cnt_width(HALF);
  localparam int unsigned   HW       = cnt_width(RST_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES);

  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic          tick;

  assign tick = (cnt == '0);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      hold     <= '0;
      rstb_out <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      if (tick) begin
        clk_out <= ~clk_out;
        // clk_out low now means this tick is a rising edge.
        if (!clk_out) begin
          if (hold != HOLD_MAX) hold <= hold + HW'(1);
        end else if (hold == HOLD_MAX) begin
          rstb_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_management_core.sv
// clock_management_core: derives 100 MHz and 10 MHz phase-0 clocks from clk_in
// and one active-low reset per derived domain.
//   clk_in        : master clock (CLK_FREQUENCY Hz)
//   rst           : synchronous active-high reset
//   clk_f100_p0   : 100 MHz, 50% duty
//   clk_f10_p0    : 10 MHz, 50% duty, rises together with clk_f100_p0
//   rstb_f100_p0  : 100 MHz domain reset (active low)
//   rstb_f10_p0   : 10 MHz domain reset (active low)
// Optional macro CLOCK_MANAGEMENT_RST_STRETCH_EN: the 10 MHz reset is also held
// until rstb_f100_p0 has been high for RST_HOLD_CYCLES clk_f10_p0 rising edges.
module clock_management_core
  import clock_management_core_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY   = 200_000_000,
  parameter int unsigned RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_f100_p0,
  output logic clk_f10_p0,
  output logic rstb_f100_p0,
  output logic rstb_f10_p0
);

  localparam int unsigned HALF100 = half_ratio(CLK_FREQUENCY, F100_HZ);
  localparam int unsigned HALF10  = half_ratio(CLK_FREQUENCY, F10_HZ);

  if (CLK_FREQUENCY % BASE_HZ != 0) begin : g_bad_freq
    $error("clock_management_core: CLK_FREQUENCY must be a multiple of 200 MHz");
  end

  logic rstb_f10_raw;

  clock_divider_rst #(
    .HALF            (HALF100),
    .RST_HOLD_CYCLES (RST_HOLD_CYCLES)
  ) u_div_f100 (
    .clk_in   (clk_in),
    .rst      (rst),
    .clk_out  (clk_f100_p0),
    .rstb_out (rstb_f100_p0)
  );

  clock_divider_rst #(
    .HALF            (HALF10),
    .RST_HOLD_CYCLES (RST_HOLD_CYCLES)
  ) u_div_f10 (
    .clk_in   (clk_in),
    .rst      (rst),
    .clk_out  (clk_f10_p0),
    .rstb_out (rstb_f10_raw)
  );

`ifdef CLOCK_MANAGEMENT_RST_STRETCH_EN
  localparam int unsigned   SW          = cnt_width(RST_HOLD_CYCLES + 1);
  localparam logic [SW-1:0] STRETCH_MAX = SW'(RST_HOLD_CYCLES);

  logic          clk_f10_q;
  logic [SW-1:0] stretch;
  logic          rstb_f10_r;

  // Edges of clk_f10_p0 are seen one clk_in cycle late via clk_f10_q; the
  // release still lands right after a falling edge, well before the next rise.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      clk_f10_q  <= 1'b0;
      stretch    <= '0;
      rstb_f10_r <= 1'b0;
    end else begin
      clk_f10_q <= clk_f10_p0;
      if (rstb_f100_p0 && clk_f10_p0 && !clk_f10_q && stretch != STRETCH_MAX)
        stretch <= stretch + SW'(1);
      if (rstb_f10_raw && stretch == STRETCH_MAX && clk_f10_q && !clk_f10_p0)
        rstb_f10_r <= 1'b1;
    end
  end

  assign rstb_f10_p0 = rstb_f10_r;
`else
  assign rstb_f10_p0 = rstb_f10_raw;
`endif

endmodule

// File: tb/tb_clock_management_core.sv
module tb_clock_management_core;

  localparam int unsigned CLK_FREQUENCY = 200_000_000;
  localparam int unsigned N             = 16;
  localparam int          PERIOD        = 10;
  localparam int unsigned H100          = CLK_FREQUENCY / 200_000_000;
  localparam int unsigned H10           = CLK_FREQUENCY / 20_000_000;
  // Edge index (1 = first clk_in edge with rst low) after which rstb is high.
  localparam int unsigned REL100        = 1 + (N - 1) * 2 * H100 + H100;
`ifdef CLOCK_MANAGEMENT_RST_STRETCH_EN
  localparam int unsigned K0            = (REL100 - 1 + 2 * H10 - 1) / (2 * H10);
  localparam int unsigned REL10         = 1 + 2 * H10 * (K0 + N - 1) + H10 + 1;
`else
  localparam int unsigned REL10         = 1 + (N - 1) * 2 * H10 + H10;
`endif

  typedef struct packed {
    logic c100;
    logic c10;
    logic r100;
    logic r10;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_f100_p0, clk_f10_p0, rstb_f100_p0, rstb_f10_p0;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int unsigned t_model = 0;
  logic measure_en = 1'b0;
  logic done = 1'b0;

  clock_management_core #(
    .CLK_FREQUENCY   (CLK_FREQUENCY),
    .RST_HOLD_CYCLES (N)
  ) dut (
    .clk_in       (clk),
    .rst          (rst),
    .clk_f100_p0  (clk_f100_p0),
    .clk_f10_p0   (clk_f10_p0),
    .rstb_f100_p0 (rstb_f100_p0),
    .rstb_f10_p0  (rstb_f10_p0)
  );

  always #(PERIOD / 2) clk = ~clk;

  // Reference: outputs as a function of edges elapsed since reset release.
  function automatic exp_t model(input int unsigned t);
    exp_t e;
    e = '0;
    if (t != 0) begin
      e.c100 = (((t - 1) / H100) % 2) == 0;
      e.c10  = (((t - 1) / H10) % 2) == 0;
      e.r100 = t >= REL100;
      e.r10  = t >= REL10;
    end
    return e;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_num(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive rst for the next clk_in edge and queue the expected outputs after it.
  task automatic step(input logic r);
    rst = r;
    t_model = r ? 0 : t_model + 1;
    exp_q.push_back(model(t_model));
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    int unsigned len;
    for (int unsigned i = 0; i < 10; i++) step(1'b1);
    for (int unsigned i = 1; i <= 1000; i++) begin
      measure_en = (i >= 200) && (i < 480);
      step(i == 500);
    end
    measure_en = 1'b0;
    for (int unsigned i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        len = $urandom_range(1, 3);
        for (int unsigned k = 0; k < len; k++) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk_num("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : monitor
    exp_t   e;
    logic   p100 = 1'b0;
    logic   p10  = 1'b0;
    longint r100_t = -1;
    longint r10_t  = -1;
    longint now;
    forever begin
      @(negedge clk);
      if (done) break;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_underflow at %0t: got empty queue expected an entry", $time);
      end else begin
        e = exp_q.pop_front();
        chk_bit("clk_f100_p0", clk_f100_p0, e.c100);
        chk_bit("clk_f10_p0", clk_f10_p0, e.c10);
        chk_bit("rstb_f100_p0", rstb_f100_p0, e.r100);
        chk_bit("rstb_f10_p0", rstb_f10_p0, e.r10);
      end
      now = longint'($time);
      if (!measure_en) begin
        r100_t = -1;
        r10_t  = -1;
      end else begin
        if (clk_f10_p0 && !p10)
          chk_bit("f10_rise_aligned", clk_f100_p0 && !p100, 1'b1);
        if (clk_f100_p0 && !p100) begin
          if (r100_t >= 0) chk_num("f100_period", now - r100_t, 2 * H100 * PERIOD);
          r100_t = now;
        end
        if (!clk_f100_p0 && p100 && r100_t >= 0)
          chk_num("f100_high", now - r100_t, H100 * PERIOD);
        if (clk_f10_p0 && !p10) begin
          if (r10_t >= 0) chk_num("f10_period", now - r10_t, 2 * H10 * PERIOD);
          r10_t = now;
        end
        if (!clk_f10_p0 && p10 && r10_t >= 0)
          chk_num("f10_high", now - r10_t, H10 * PERIOD);
      end
      p100 = clk_f100_p0;
      p10  = clk_f10_p0;
    end
  end

  initial begin : watchdog
    #(PERIOD * 20000);
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
